// File: rtl/bitwise_arb_if.sv
// Requester/result handshake bundle for bitwise_arb.
// master drives requests and res_ready; slave is the arbiter.
interface bitwise_arb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       res_valid;
  logic       res_ready;
  logic       res_id;
  logic       res_even;
  logic       res_odd;
  logic       res_allone;

  modport master (
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready,
    input  res_valid,
    output res_ready,
    input  res_id, res_even,
    input  res_odd, res_allone
  );

  modport slave (
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready,
    output res_valid,
    input  res_ready,
    output res_id, res_even,
    output res_odd, res_allone
  );
endinterface

// File: rtl/bitwise_arb.sv
// Two-requester round-robin arbiter that evaluates byte parity/all-ones
// and counts all-ones results per requester with saturation.
module bitwise_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bitwise_arb_if.slave     bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       last;
  logic [7:0] data_q;
  logic       id_q;
  logic       rv_q;
  logic       rid_q;
  logic       even_q;
  logic       odd_q;
  logic       all_q;
  logic       g0;
  logic       g1;
  logic       rel;

  // last=1 means req1 was served last, so req0 wins a tie
  always_comb begin
    state_n = state;
    g0      = 1'b0;
    g1      = 1'b0;
    unique case (state)
      IDLE: begin
        g0 = bus.req0_valid
           & (~bus.req1_valid | last);
        g1 = bus.req1_valid
           & (~bus.req0_valid | ~last);
        if (g0 | g1) state_n = EVAL;
      end
      EVAL: state_n = HOLD;
      HOLD: if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rel = (state == HOLD) & bus.res_ready;

  assign bus.req0_ready = g0 & rst_n;
  assign bus.req1_ready = g1 & rst_n;
  assign bus.res_valid  = rv_q;
  assign bus.res_id     = rid_q;
  assign bus.res_even   = even_q;
  assign bus.res_odd    = odd_q;
  assign bus.res_allone = all_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      data_q <= '0;
      id_q   <= 1'b0;
      rv_q   <= 1'b0;
      rid_q  <= 1'b0;
      even_q <= 1'b0;
      odd_q  <= 1'b0;
      all_q  <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
    end else begin
      state <= state_n;
      if (g0 | g1) begin
        data_q <= g1 ? bus.req1_data
                     : bus.req0_data;
        id_q   <= g1;
      end
      if (state == EVAL) begin
        rv_q   <= 1'b1;
        rid_q  <= id_q;
        odd_q  <= ^data_q;
        even_q <= ~^data_q;
        all_q  <= &data_q;
      end
      if (rel) begin
        rv_q <= 1'b0;
        last <= rid_q;
        if (all_q && !rid_q && cnt0 != '1)
          cnt0 <= cnt0 + CNT_W'(1);
        if (all_q && rid_q && cnt1 != '1)
          cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bitwise_arb.sv
// Randomized and directed bench for bitwise_arb against a
// transaction-level model; a CNT_W=2 copy exercises saturation.
module tb_bitwise_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitwise_arb_if a_if ();
  bitwise_arb_if b_if ();

  logic [7:0] a_c0, a_c1;
  logic [1:0] b_c0, b_c1;

  bitwise_arb #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if),
    .cnt0  (a_c0),
    .cnt1  (a_c1)
  );

  bitwise_arb #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if),
    .cnt0  (b_c0),
    .cnt1  (b_c1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // transaction-level model: one result in flight at a time
  bit         m_busy;
  int         m_age;
  bit         m_last;
  bit         m_id;
  logic [7:0] m_data;
  int         m_cnt [2];
  int         m_cnt2 [2];

  function automatic void m_reset();
    m_busy = 0;
    m_age  = 0;
    m_last = 1;
    m_id   = 0;
    m_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_cnt2[i] = 0;
    end
  endfunction

  task automatic drive(bit v0, logic [7:0] d0,
                       bit v1, logic [7:0] d1,
                       bit rr);
    a_if.req0_valid = v0;
    a_if.req0_data  = d0;
    a_if.req1_valid = v1;
    a_if.req1_data  = d1;
    a_if.res_ready  = rr;
    b_if.req0_valid = v0;
    b_if.req0_data  = d0;
    b_if.req1_valid = v1;
    b_if.req1_data  = d1;
    b_if.res_ready  = rr;
  endtask

  // one clock: drive at negedge, check, advance at posedge
  task automatic cycle(bit v0, logic [7:0] d0,
                       bit v1, logic [7:0] d1,
                       bit rr);
    bit g0, g1, vis;
    drive(v0, d0, v1, d1, rr);
    #1;
    g0  = !m_busy && v0 && (!v1 || m_last);
    g1  = !m_busy && v1 && (!v0 || !m_last);
    vis = m_busy && m_age >= 1;
    chk("rdy0", a_if.req0_ready, g0);
    chk("rdy1", a_if.req1_ready, g1);
    chk("rvld", a_if.res_valid, vis);
    if (vis) begin
      chk("rid", a_if.res_id, m_id);
      chk("even", a_if.res_even,
          ($countones(m_data) % 2) == 0);
      chk("odd", a_if.res_odd,
          ($countones(m_data) % 2) == 1);
      chk("all", a_if.res_allone,
          m_data == 8'hFF);
    end
    chk("cnt0", a_c0, m_cnt[0]);
    chk("cnt1", a_c1, m_cnt[1]);
    chk("s_cnt0", b_c0, m_cnt2[0]);
    chk("s_cnt1", b_c1, m_cnt2[1]);
    @(posedge clk);
    if (m_busy) begin
      if (m_age >= 1 && rr) begin
        m_last = m_id;
        if (m_data == 8'hFF) begin
          if (m_cnt[m_id] < 255) m_cnt[m_id]++;
          if (m_cnt2[m_id] < 3) m_cnt2[m_id]++;
        end
        m_busy = 0;
      end else if (m_age < 1) begin
        m_age++;
      end
    end else if (g0 || g1) begin
      m_busy = 1;
      m_age  = 0;
      m_id   = g1;
      m_data = g1 ? d1 : d0;
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rv"}, a_if.res_valid, 0);
    chk({tag, "_id"}, a_if.res_id, 0);
    chk({tag, "_ev"}, a_if.res_even, 0);
    chk({tag, "_od"}, a_if.res_odd, 0);
    chk({tag, "_al"}, a_if.res_allone, 0);
    chk({tag, "_r0"}, a_if.req0_ready, 0);
    chk({tag, "_r1"}, a_if.req1_ready, 0);
    chk({tag, "_c0"}, a_c0, 0);
    chk({tag, "_c1"}, a_c1, 0);
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    m_reset();
    drive(1, 8'hFF, 1, 8'hFF, 1);
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // req0 all-ones, then req1 three ones
    cycle(1, 8'hFF, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    chk("lat_rv", a_if.res_valid, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    chk("c0_one", a_c0, 1);
    cycle(0, 8'h00, 1, 8'h92, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // continuous contention alternates
    for (int i = 0; i < 12; i++)
      cycle(1, 8'h96, 1, 8'hFF, 1);

    // backpressure then single-cycle release
    cycle(1, 8'h5A, 1, 8'hA5, 0);
    for (int i = 0; i < 10; i++)
      cycle(1, 8'h5A, 1, 8'hA5, 0);
    cycle(1, 8'h5A, 1, 8'hA5, 1);
    cycle(1, 8'h5A, 1, 8'hA5, 0);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // reset while an all-ones result is held
    cycle(1, 8'hFF, 0, 8'h00, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    drive(1, 8'hFF, 1, 8'hFF, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'h01, 1, 8'h02, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // saturation on the narrow copy
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 8'hFF, 0, 8'h00, 1);
      cycle(0, 8'h00, 0, 8'h00, 1);
      cycle(0, 8'h00, 0, 8'h00, 1);
      chk("sat", b_c0, sat_exp[k]);
    end

    // random traffic with withdrawals
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d0, d1;
      d0 = ($urandom % 3 == 0) ? 8'hFF
                               : 8'($urandom);
      d1 = ($urandom % 3 == 0) ? 8'hFF
                               : 8'($urandom);
      cycle(($urandom % 10) < 7, d0,
            ($urandom % 10) < 7, d1,
            ($urandom % 10) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
